rast_hit_fifo: RTL and testbench
================================

// Module: rast_hit_fifo
// PURPOSE
// - Sits directly downstream of the sample-test stage. Collects hit samples (position, colour, depth) into a FIFO.
// - Drains them to the framebuffer/zbuffer writer through a valid/ready handshake.
// - Drives the upstream halt early enough to absorb every sample still in flight in the PIPES_SAMP-deep sample pipe.
// PARAMETERS
// - DEPTH  default 8             FIFO entries; power of two, >= SLACK+2
// - SLACK  default PIPES_SAMP+1  free entries reserved for in-flight samples when halt rises
// - (SIGFIG, COLORS from rast_params; a sample position is 2 x SIGFIG: x, y)
// PORTS
// - clk        in   1                   clock, rising edge
// - rst        in   1                   asynchronous, active-high reset
// - in_valid   in   1                   upstream sample valid this cycle
// - in_hit     in   1                   sample lies inside the micropolygon
// - in_samp    in   2*SIGFIG            sample x, y (fixed point, RADIX frac bits)
// - in_color   in   COLORS*SIGFIG       sample colour
// - in_depth   in   SIGFIG              sample z
// - halt_up    out  1                   stall request to the bbox/iter/sample stages
// - out_valid  out  1                   head entry valid
// - out_ready  in   1                   downstream accepts head
// - out_samp   out  2*SIGFIG            head position
// - out_color  out  COLORS*SIGFIG       head colour
// - out_depth  out  SIGFIG              head depth
// - occupancy  out  $clog2(DEPTH)+1     current entry count
// - overflow   out  1                   sticky: a hit was dropped
// BEHAVIOUR
// - Reset values (asynchronous):
//   - count, rd_ptr, wr_ptr = 0
//   - halt_up, out_valid, overflow = 0
//   - out_* data = 0
// - push = in_valid & in_hit. Misses (in_hit=0) are discarded silently and do not set overflow.
// - pop = out_valid & out_ready.
// - Latency: an entry pushed at edge N is visible at out_* after edge N (out_valid=1 in cycle N+1) if the FIFO was empty.
//   - No combinational path from in_* to out_*.
// - Output data is the head entry, registered.
//   - out_* holds stable while out_valid=1 and out_ready=0.
// - Simultaneous push+pop:
//   - count unchanged; both pointers advance.
//   - Allowed at full: the pop frees the slot the push uses.
// - Push while full and no pop: entry dropped, overflow <= 1, count unchanged. overflow clears only on rst.
// - Pop while empty: impossible by construction (out_valid=0); out_ready is ignored.
// - Pointers wrap modulo DEPTH. count is 0..DEPTH inclusive.
// - halt_up is registered. Next-cycle value = (count_next >= DEPTH-SLACK).
//   - Deasserts once count_next < DEPTH-SLACK (no hysteresis).
// - With halt_up high, upstream may still deliver up to SLACK valid samples. No drop may occur while upstream honours halt.
// - Reset mid-operation: all contents are discarded immediately. out_valid drops asynchronously.
// - occupancy = count (registered).
// CONFIGURATION
// - Macro RAST_HIT_STATS_EN.
// - Defined: adds two outputs, both counting from reset and saturating at all-ones:
//   - hit_count  out 32: accepted pushes
//   - drop_count out 16: dropped pushes
// - Undefined: both ports and their counters are absent; all other behaviour is identical.
// STRUCTURE
// - In rast_params:
//   - sample_t struct: samp[2], color[COLORS], depth, each logic [SIGFIG-1:0]
//   - localparam HIT_FIFO_DEPTH = 8
//   - localparam HIT_FIFO_SLACK = PIPES_SAMP+1
// - Sub-module rast_fifo_mem: DEPTH x $bits(sample_t) register array.
//   - One synchronous write port; one read port addressed by rd_ptr_next, registered output.
// - rast_hit_fifo owns pointers, count, halt, overflow and the optional stats counters.
// TESTING
// - Reset with FIFO half full -> out_valid=0, occupancy=0, halt_up=0, overflow=0 in the same cycle rst rises.
// - 8 consecutive hits, out_ready=0, DEPTH=8, SLACK=3:
//   - halt_up=1 in the cycle after the 5th push
//   - occupancy=8, overflow=0
//   - 9th hit -> overflow=1, occupancy stays 8
// - Alternating in_hit=1/0 for 6 samples, out_ready=1 -> exactly 3 outputs, in push order, x values match, occupancy <= 1.
// - Full FIFO, push+pop in the same cycle -> occupancy stays 8, no overflow, popped entry = oldest.
// - out_ready toggled randomly for 1000 hits, upstream honouring halt -> zero drops.
//   - Output sequence equals input hit sequence. Pointers wrap more than 100 times.
// - RAST_HIT_STATS_EN defined, 10 hits + 2 drops -> hit_count=10, drop_count=2. Undefined: the bench compiles without these ports.

Source files
------------

// File: rtl/rast_hit_fifo_pkg.sv
// rast_params: shared rasteriser parameters and the hit-sample record.
// Contents:
//   SIGFIG, RADIX, COLORS  fixed-point word size, fractional bits, colour channels
//   PIPES_SAMP             depth of the sample-test pipe feeding the hit FIFO
//   HIT_FIFO_DEPTH/SLACK   default hit FIFO geometry
//   sample_t               one hit: position (x, y), colour, depth
package rast_params;
  localparam int SIGFIG     = 24;
  localparam int RADIX      = 10;
  localparam int COLORS     = 3;
  localparam int PIPES_SAMP = 2;

  localparam int HIT_FIFO_DEPTH = 8;
  localparam int HIT_FIFO_SLACK = PIPES_SAMP + 1;

  // samp[0] is x, samp[1] is y
  typedef struct packed {
    logic [1:0][SIGFIG-1:0]      samp;
    logic [COLORS-1:0][SIGFIG-1:0] color;
    logic [SIGFIG-1:0]           depth;
  } sample_t;
endpackage

// File: rtl/rast_fifo_mem.sv
// rast_fifo_mem: DEPTH x sample_t register array for the hit FIFO.
// Ports:
//   clk, rst          clock; asynchronous active-high reset (read register only)
//   wr_en/addr/data   synchronous write port
//   rd_addr           read address (the FIFO's next read pointer)
//   rd_data           registered read data
// A write to the slot being read in the same cycle is forwarded, so an entry
// written into an empty FIFO appears on rd_data right after its write edge.
module rast_fifo_mem
  import rast_params::*;
#(
  parameter int DEPTH = HIT_FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  sample_t       wr_data,
  input  logic [AW-1:0] rd_addr,
  output sample_t       rd_data
);

  sample_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             rd_data <= '0;
    else if (wr_en && wr_addr == rd_addr) rd_data <= wr_data;
    else                                 rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/rast_hit_fifo.sv
// rast_hit_fifo: collects hit samples from the sample-test stage and drains
// them to the framebuffer/zbuffer writer over valid/ready.
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   in_valid, in_hit              upstream sample strobe; only hits are stored
//   in_samp/in_color/in_depth     sample payload
//   halt_up                       registered stall request to upstream stages
//   out_valid, out_ready          head handshake
//   out_samp/out_color/out_depth  registered head entry
//   occupancy                     entry count
//   overflow                      sticky: a hit was dropped at full
// Optional (macro RAST_HIT_STATS_EN): hit_count (accepted pushes, 32 bit) and
// drop_count (dropped pushes, 16 bit), both saturating.
module rast_hit_fifo
  import rast_params::*;
#(
  parameter int DEPTH = HIT_FIFO_DEPTH,
  parameter int SLACK = HIT_FIFO_SLACK,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_hit,
  input  logic [2*SIGFIG-1:0]      in_samp,
  input  logic [COLORS*SIGFIG-1:0] in_color,
  input  logic [SIGFIG-1:0]        in_depth,
  output logic                     halt_up,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*SIGFIG-1:0]      out_samp,
  output logic [COLORS*SIGFIG-1:0] out_color,
  output logic [SIGFIG-1:0]        out_depth,
  output logic [CW-1:0]            occupancy,
`ifdef RAST_HIT_STATS_EN
  output logic [31:0]              hit_count,
  output logic [15:0]              drop_count,
`endif
  output logic                     overflow
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] HALT_C = CW'(DEPTH - SLACK);

  logic [CW-1:0] count, count_next;
  logic [AW-1:0] rd_ptr, rd_ptr_next, wr_ptr;
  logic          push, pop, wr_en, drop;
  sample_t       wr_data, rd_data;

  assign push = in_valid & in_hit;
  assign pop  = out_valid & out_ready;
  // At full a push only lands if the head leaves in the same cycle.
  assign wr_en = push & ((count != FULL_C) | pop);
  assign drop  = push & (count == FULL_C) & ~pop;

  // Pointers are AW bits wide, so the +1 wraps modulo DEPTH.
  assign rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    count_next = count;
    case ({wr_en, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_comb begin
    wr_data       = '0;
    wr_data.samp  = in_samp;
    wr_data.color = in_color;
    wr_data.depth = in_depth;
  end

  rast_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_next),
    .rd_data (rd_data)
  );

  assign out_samp  = rd_data.samp;
  assign out_color = rd_data.color;
  assign out_depth = rd_data.depth;
  assign occupancy = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
      halt_up   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      count     <= count_next;
      rd_ptr    <= rd_ptr_next;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      out_valid <= (count_next != '0);
      // Threshold leaves SLACK free slots for samples already in the pipe.
      halt_up   <= (count_next >= HALT_C);
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef RAST_HIT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      drop_count <= '0;
    end else begin
      if (wr_en && hit_count != '1)  hit_count  <= hit_count + 32'd1;
      if (drop && drop_count != '1)  drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rast_hit_fifo.sv
// Self-checking bench for rast_hit_fifo: a queue-based reference model is
// compared against the DUT every cycle, plus literal expectations for the
// directed scenarios (reset, fill/halt/overflow, alternating hits, full
// push+pop, long random-ready run with upstream honouring halt).
module tb_rast_hit_fifo;
  import rast_params::*;

  localparam int DEPTH = HIT_FIFO_DEPTH;
  localparam int SLACK = HIT_FIFO_SLACK;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid, in_hit, out_ready;
  logic [2*SIGFIG-1:0]      in_samp;
  logic [COLORS*SIGFIG-1:0] in_color;
  logic [SIGFIG-1:0]        in_depth;
  logic                     halt_up, out_valid, overflow;
  logic [2*SIGFIG-1:0]      out_samp;
  logic [COLORS*SIGFIG-1:0] out_color;
  logic [SIGFIG-1:0]        out_depth;
  logic [CW-1:0]            occupancy;
`ifdef RAST_HIT_STATS_EN
  logic [31:0]              hit_count;
  logic [15:0]              drop_count;
`endif

  sample_t din;
  assign in_samp  = din.samp;
  assign in_color = din.color;
  assign in_depth = din.depth;

  rast_hit_fifo dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_hit     (in_hit),
    .in_samp    (in_samp),
    .in_color   (in_color),
    .in_depth   (in_depth),
    .halt_up    (halt_up),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_samp   (out_samp),
    .out_color  (out_color),
    .out_depth  (out_depth),
    .occupancy  (occupancy),
`ifdef RAST_HIT_STATS_EN
    .hit_count  (hit_count),
    .drop_count (drop_count),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic sample_t mk(input int i);
    sample_t s;
    s.samp[0] = SIGFIG'(i);
    s.samp[1] = SIGFIG'(i + 1000);
    for (int k = 0; k < COLORS; k++) s.color[k] = SIGFIG'(i * 3 + k);
    s.depth = ~SIGFIG'(i);
    return s;
  endfunction

  // Reference model: an ordered queue of stored hits.
  sample_t q[$];
  bit      ovf_m, halt_m;
  int      hits_m, drops_m;
  bit      pop_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      ovf_m = 0; halt_m = 0; hits_m = 0; drops_m = 0;
    end else begin
      pop_m = (q.size() > 0) && out_ready;
      if (pop_m) void'(q.pop_front());
      if (in_valid && in_hit) begin
        if (q.size() < DEPTH) begin
          q.push_back(din);
          hits_m++;
        end else begin
          ovf_m = 1;
          drops_m++;
        end
      end
      halt_m = (q.size() >= DEPTH - SLACK);
    end
  end

  // Per-cycle compare; also logs DUT pops (x of each popped head, in order).
  bit                chk_en = 0;
  bit                prev_valid = 0;
  logic [SIGFIG-1:0] prev_x;
  logic [SIGFIG-1:0] xs[$];
  int                pops = 0;
  int                max_occ = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
    end else if (chk_en) begin
      // out_ready still holds the value the last rising edge consumed
      if (prev_valid && out_ready) begin
        pops++;
        xs.push_back(prev_x);
      end
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("halt_up", 64'(halt_up), 64'(halt_m));
      chk("overflow", 64'(overflow), 64'(ovf_m));
`ifdef RAST_HIT_STATS_EN
      chk("hit_count", 64'(hit_count), 64'(hits_m));
      chk("drop_count", 64'(drop_count), 64'(drops_m));
`endif
      if (q.size() != 0) begin
        tests++;
        if ({out_samp, out_color, out_depth} !== q[0]) begin
          fails++;
          $display("FAIL head_data: got %h, expected %h", {out_samp, out_color, out_depth}, q[0]);
        end
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      prev_valid = out_valid;
      prev_x     = out_samp[SIGFIG-1:0];
    end
  end

  task automatic drive(input logic v, input logic h, input logic r, input sample_t s);
    in_valid  = v;
    in_hit    = h;
    out_ready = r;
    din       = s;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && occupancy != 0; k++) drive(1'b0, 1'b0, 1'b1, din);
    chk("drain_empty", 64'(occupancy), 64'd0);
  endtask

  logic [SIGFIG-1:0]       sent_x[$];
  logic [PIPES_SAMP-1:0]   hh;
  int                      sent;
  bit                      v, h, seq_ok;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_hit = 1'b0; out_ready = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_halt", 64'(halt_up), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_data", 64'({out_samp, out_color, out_depth} == '0), 64'd1);
    rst = 1'b0;
    chk_en = 1;

    // Half fill, then asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, mk(i));
    chk("pre_rst_occ", 64'(occupancy), 64'd5);
    chk("pre_rst_halt", 64'(halt_up), 64'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_halt", 64'(halt_up), 64'd0);
    chk("arst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Fill to DEPTH with no drain; halt after the 5th push
    xs.delete(); pops = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, mk(10 + i));
      if (i == 3) chk("halt_after_4", 64'(halt_up), 64'd0);
      if (i == 4) chk("halt_after_5", 64'(halt_up), 64'd1);
    end
    chk("full_occ", 64'(occupancy), 64'd8);
    chk("full_ovf", 64'(overflow), 64'd0);
    chk("full_head_x", 64'(out_samp[SIGFIG-1:0]), 64'd10);

    // Push + pop at full
    drive(1'b1, 1'b1, 1'b1, mk(18));
    chk("pp_occ", 64'(occupancy), 64'd8);
    chk("pp_ovf", 64'(overflow), 64'd0);
    chk("pp_popped_oldest", 64'(xs.size() == 1 ? xs[0] : '1), 64'd10);
    chk("pp_new_head_x", 64'(out_samp[SIGFIG-1:0]), 64'd11);

    // 9th hit with no pop is dropped
    drive(1'b1, 1'b1, 1'b0, mk(19));
    chk("drop_ovf", 64'(overflow), 64'd1);
    chk("drop_occ", 64'(occupancy), 64'd8);
    drive(1'b1, 1'b1, 1'b0, mk(20));
    drive(1'b1, 1'b1, 1'b1, mk(21));
`ifdef RAST_HIT_STATS_EN
    chk("stats_hits", 64'(hit_count), 64'd10);
    chk("stats_drops", 64'(drop_count), 64'd2);
`endif
    drain();

    // Alternating hit/miss with the sink always ready
    xs.delete(); pops = 0; max_occ = 0;
    for (int i = 0; i < 6; i++) drive(1'b1, (i % 2) == 0, 1'b1, mk(100 + i));
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, din);
    chk("alt_pops", 64'(pops), 64'd3);
    chk("alt_x0", 64'(xs.size() > 0 ? xs[0] : '1), 64'd100);
    chk("alt_x1", 64'(xs.size() > 1 ? xs[1] : '1), 64'd102);
    chk("alt_x2", 64'(xs.size() > 2 ? xs[2] : '1), 64'd104);
    chk("alt_occ_le1", 64'(max_occ <= 1), 64'd1);
    chk("alt_ovf_sticky", 64'(overflow), 64'd1);

    // Random sink, upstream honouring halt with a pipe delay
    rst = 1'b1;
    #1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    xs.delete(); sent_x.delete(); pops = 0; sent = 0; hh = '0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      v = !hh[PIPES_SAMP-1] && ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 4) != 0);
      if (v && h) begin
        sent_x.push_back(SIGFIG'(2000 + sent));
        sent++;
      end
      drive(v, h, 1'($urandom_range(0, 1)), mk(2000 + sent - ((v && h) ? 1 : 0)));
      hh = (hh << 1) | PIPES_SAMP'(halt_up);
    end
    drain();
    chk("rand_sent", 64'(sent), 64'd1000);
    chk("rand_drops", 64'(drops_m), 64'd0);
    chk("rand_ovf", 64'(overflow), 64'd0);
    chk("rand_pops", 64'(pops), 64'd1000);
    chk("rand_wraps_gt100", 64'((pops / DEPTH) > 100), 64'd1);
    seq_ok = (xs.size() == sent_x.size());
    for (int k = 0; k < xs.size() && seq_ok; k++) if (xs[k] !== sent_x[k]) seq_ok = 0;
    chk("rand_order", 64'(seq_ok), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
